// File: rtl/agc_pkg.sv
// agc_pkg: shared widths, encodings and ones-complement helpers for the AGC datapath
// No ports. Encodings match the control FSM's alu_op and mux select fields.
package agc_pkg;
    localparam int WORD_W = 15;
    localparam int ADDR_W = 12;
    localparam int MAG_W  = WORD_W - 1;
    localparam logic [ADDR_W-1:0] RESET_PC = 12'h800;
    localparam logic [WORD_W-1:0] POS_ZERO = 15'h0000;
    localparam logic [WORD_W-1:0] POS_ONE  = 15'h0001;
    localparam logic [WORD_W-1:0] NEG_ONE  = 15'h7FFE;
    localparam logic [WORD_W-1:0] NEG_ZERO = 15'h7FFF;
    localparam logic [MAG_W-1:0]  MAG_MAX  = 14'h3FFF;
    typedef enum logic [2:0] {ALU_AD, ALU_SU, ALU_MASK, ALU_MP0, ALU_MP1, ALU_DV0, ALU_DV1, ALU_NOP} alu_op_e;
    typedef enum logic [1:0] {A_MEM, A_ALU, A_NOTG, A_G} a_sel_e;
    typedef enum logic [1:0] {Q_A, Q_ALU, Q_Z, Q_MEM} q_sel_e;
    typedef enum logic [1:0] {X_A, X_Z, X_B, X_G} x_sel_e;
    typedef enum logic [1:0] {Z_B, Z_ALU, Z_B2, Z_MEM} z_sel_e;
    typedef enum logic [2:0] {Y_ZERO, Y_MEM, Y_ONE, Y_NEG1, Y_ABSA} y_sel_e;
    function automatic logic [MAG_W-1:0] mag(input logic [WORD_W-1:0] v);
        return v[WORD_W-1] ? ~v[MAG_W-1:0] : v[MAG_W-1:0];
    endfunction
    function automatic logic [WORD_W-1:0] signed_as(input logic s, input logic [MAG_W-1:0] m);
        return {s, s ? ~m : m};
    endfunction
endpackage

// File: rtl/agc_alu.sv
// agc_alu: combinational 15-bit ones-complement ALU (add/sub, mask, multiply, divide)
// Ports: op_i (alu_op), x_i/y_i (operands), res_o (result).
module agc_alu
    import agc_pkg::*;
(
    input  logic [2:0]        op_i,
    input  logic [WORD_W-1:0] x_i,
    input  logic [WORD_W-1:0] y_i,
    output logic [WORD_W-1:0] res_o
);
    logic [MAG_W-1:0]   mx, my, quo, rem;
    logic [WORD_W:0]    sum;
    logic [2*MAG_W-1:0] prod;
    logic               ps;
    always_comb begin
        mx   = mag(x_i);
        my   = mag(y_i);
        sum  = {1'b0, x_i} + {1'b0, op_i == ALU_SU ? ~y_i : y_i};
        prod = {{MAG_W{1'b0}}, mx} * {{MAG_W{1'b0}}, my};
        ps   = x_i[WORD_W-1] ^ y_i[WORD_W-1];
        // divide by +/-0 saturates the quotient and passes X through as remainder
        quo  = my == '0 ? MAG_MAX : mx / my;
        rem  = my == '0 ? mx : mx % my;
        case (op_i)
            // end-around carry: the carry out of bit 14 is added back in
            ALU_AD, ALU_SU: res_o = sum[WORD_W-1:0] + {{(WORD_W-1){1'b0}}, sum[WORD_W]};
            ALU_MASK:       res_o = x_i & y_i;
            ALU_MP0:        res_o = signed_as(ps, prod[MAG_W-1:0]);
            ALU_MP1:        res_o = signed_as(ps, prod[2*MAG_W-1:MAG_W]);
            ALU_DV0:        res_o = signed_as(x_i[WORD_W-1], rem);
            ALU_DV1:        res_o = signed_as(ps, quo);
            default:        res_o = POS_ZERO;
        endcase
    end
endmodule

// File: rtl/agc_datapath.sv
// agc_datapath: AGC register/ALU datapath executing the control FSM's write and mux strobes
// Ports: clk/rst; ext_flag -> extracode; *_wr write strobes; *_mux source selects; alu_op;
//        mem_addr/mem_wdata/mem_we/mem_rdata memory side; opcode/qc decode of B; a_out/z_out debug.
// Optional: define AGC_OVF_FLAG_EN to add the sticky ovf output for AD/SU results written to A.
module agc_datapath
    import agc_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC_P = RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ext_flag,
    input  logic              mem_wr,
    input  logic              lp_wr,
    input  logic              g_wr,
    input  logic              q_wr,
    input  logic              b_wr,
    input  logic              a_wr,
    input  logic              y_wr,
    input  logic              x_wr,
    input  logic              z_wr,
    input  logic              maddr_mux,
    input  logic              mdata_mux,
    input  logic              lp_mux,
    input  logic              g_mux,
    input  logic              b_mux,
    input  logic [1:0]        q_mux,
    input  logic [1:0]        a_mux,
    input  logic [1:0]        x_mux,
    input  logic [1:0]        z_mux,
    input  logic [2:0]        y_mux,
    input  logic [2:0]        alu_op,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [2:0]        opcode,
    output logic [1:0]        qc,
    output logic              extracode,
`ifdef AGC_OVF_FLAG_EN
    output logic              ovf,
`endif
    output logic [WORD_W-1:0] a_out,
    output logic [ADDR_W-1:0] z_out
);
    logic [WORD_W-1:0] a_q, b_q, g_q, q_q, x_q, y_q, lp_q;
    logic [WORD_W-1:0] a_d, b_d, g_d, q_d, x_d, y_d, lp_d;
    logic [ADDR_W-1:0] z_q, z_d;
    logic              ext_q;
    logic [WORD_W-1:0] alu_res, z_ext;
    agc_alu u_alu (.op_i(alu_op), .x_i(x_q), .y_i(y_q), .res_o(alu_res));
    assign z_ext = {{(WORD_W-ADDR_W){1'b0}}, z_q};
    always_comb begin
        a_d  = a_mux == A_MEM ? mem_rdata : a_mux == A_ALU ? alu_res : a_mux == A_NOTG ? ~g_q : g_q;
        b_d  = b_mux ? alu_res : mem_rdata;
        g_d  = g_mux ? a_q : mem_rdata;
        q_d  = q_mux == Q_A ? a_q : q_mux == Q_ALU ? alu_res : q_mux == Q_Z ? z_ext : mem_rdata;
        x_d  = x_mux == X_A ? a_q : x_mux == X_Z ? z_ext : x_mux == X_B ? b_q : g_q;
        y_d  = y_mux == Y_MEM ? mem_rdata : y_mux == Y_ONE ? POS_ONE : y_mux == Y_NEG1 ? NEG_ONE :
               y_mux == Y_ABSA ? {1'b0, mag(a_q)} : POS_ZERO;
        z_d  = z_mux == Z_ALU ? alu_res[ADDR_W-1:0] : z_mux == Z_MEM ? mem_rdata[ADDR_W-1:0] : b_q[ADDR_W-1:0];
        lp_d = lp_mux ? alu_res : POS_ZERO;
    end
    // every source above reads pre-edge state, so simultaneous writes never see each other
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= POS_ZERO;
            b_q   <= POS_ZERO;
            g_q   <= POS_ZERO;
            q_q   <= POS_ZERO;
            x_q   <= POS_ZERO;
            y_q   <= POS_ZERO;
            lp_q  <= POS_ZERO;
            z_q   <= RESET_PC_P;
            ext_q <= 1'b0;
        end else begin
            if (a_wr)  a_q  <= a_d;
            if (b_wr)  b_q  <= b_d;
            if (g_wr)  g_q  <= g_d;
            if (q_wr)  q_q  <= q_d;
            if (x_wr)  x_q  <= x_d;
            if (y_wr)  y_q  <= y_d;
            if (lp_wr) lp_q <= lp_d;
            if (z_wr)  z_q  <= z_d;
            ext_q <= ext_flag;
        end
    end
`ifdef AGC_OVF_FLAG_EN
    logic ovf_q, ovf_d, y_sign, add_ovf;
    always_comb begin
        y_sign  = alu_op == ALU_SU ? ~y_q[WORD_W-1] : y_q[WORD_W-1];
        add_ovf = (alu_op == ALU_AD || alu_op == ALU_SU) && x_q[WORD_W-1] == y_sign &&
                  alu_res[WORD_W-1] != x_q[WORD_W-1];
        ovf_d   = !a_wr ? ovf_q : a_mux != A_ALU ? 1'b0 : ovf_q | add_ovf;
    end
    always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end
    assign ovf = ovf_q;
`endif
    assign mem_addr  = maddr_mux ? b_q[ADDR_W-1:0] : z_q;
    assign mem_wdata = mdata_mux ? q_q : a_q;
    assign mem_we    = mem_wr;
    assign opcode    = b_q[WORD_W-1:WORD_W-3];
    assign qc        = b_q[WORD_W-4:WORD_W-5];
    assign extracode = ext_q;
    assign a_out     = a_q;
    assign z_out     = z_q;
endmodule
